fp_add_preparer_pipe: RTL and testbench
=======================================

// Module: fp_add_preparer_pipe
// PURPOSE
//  Parametrised, pipelined first stage of the FP adder. Accepts two IEEE-754-style operands
//  through a valid/ready handshake. Decodes both operands and classifies NaN/inf/denorm.
//  Picks the larger exponent, aligns and sign-converts both significands, and emits the
//  result to the adder core through a second valid/ready handshake.
//  2-stage pipeline with full backpressure; generic in exponent/fraction width (FP32 default).
// PARAMETERS
//  EXP_W   8                   exponent width
//  FRAC_W  23                  stored fraction width
//  OP_W    1+EXP_W+FRAC_W      operand width (derived, do not override)
//  MANT_W  2*FRAC_W+4          aligned mantissa width (derived; 50 for FP32)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block can accept operand pair this cycle
//  op_1       in   OP_W    operand 1 {s,e,f}
//  op_2       in   OP_W    operand 2 {s,e,f}
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  NaN_res    out  1       result is NaN
//  inf_res    out  1       result is infinity (never set together with NaN_res)
//  res_sig    out  1       result sign
//  legal      out  1       ~NaN_res & ~inf_res; mantissas/exp_max meaningful
//  exp_max    out  EXP_W   max(raw e1, raw e2)
//  mant_op_1  out  MANT_W  aligned two's-complement mantissa, op 1
//  mant_op_2  out  MANT_W  aligned two's-complement mantissa, op 2
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage-valid flags=0 and every output register=0.
//    out_valid=0 immediately; in_ready=1 while in reset. In-flight data is discarded.
//  - Latency 2 cycles from accept (in_valid&in_ready) to out_valid. Throughput 1/cycle.
//  - Handshake: s2_en = ~out_valid | out_ready; s1_en = ~s1_valid | s2_en; in_ready = s1_en.
//    A stage's registers load only when that stage is enabled. Otherwise all outputs hold
//    stable while out_valid=1 & out_ready=0. No loss, no duplication, order preserved.
//    A simultaneous accept and emit in the same cycle is legal at full rate.
//  - S1 (registered): decode {s,e,f}.
//    NaN: e=all-1, f!=0. inf: e=all-1, f=0. denorm: e=0.
//    Effective exponent ee = denorm ? 1 : e; hidden bit = ~denorm.
//    Register exp_max, del=|ee1-ee2| (EXP_W bits), gr_1/gr_2/eq, and the classification.
//  - Specials, in priority order:
//    any NaN, or inf with opposite signs -> NaN_res=1, res_sig=0.
//    else any inf -> inf_res=1, res_sig = sign of the inf operand.
//    When legal=0, mantissas are don't-care and are driven 0.
//  - S2 (registered): sig={hidden,f} is placed at [MANT_W-3 -: FRAC_W+1]. Top 2 bits
//    (sign, carry headroom) and low FRAC_W+1 bits are zero.
//    The operand with smaller ee is logically right-shifted by del. For eq, neither shifts.
//    del >= MANT_W-2 clamps: the shifted value is 0.
//    A negative-sign operand is then two's-complemented over MANT_W bits (-0 stays 0).
//  - res_sig when legal: sign of the larger magnitude, compared by ee, then f.
//    On an exact tie with opposite signs -> 0. With the same signs -> the common sign.
// CONFIGURATION
//  FP_PREP_STICKY_EN defined: bits shifted out during alignment are OR-reduced into bit 0 of
//    the shifted mantissa before negation; clamped shifts give 1 if sig!=0.
//  Not defined: shifted-out bits are dropped; bit 0 is a plain data bit.
// TESTING (FP32 defaults)
//  1. 0x3F800000 + 0x3F800000 -> +2 cycles: legal=1, exp_max=0x7F,
//     mant_op_1=mant_op_2=0x0_8000_0000_0000, res_sig=0.
//  2. 0x3F800000 + 0xBF000000 -> exp_max=0x7F, mant_op_1=0x0_8000_0000_0000,
//     mant_op_2=0x3_C000_0000_0000, res_sig=0.
//  3. 0x7F800000 + 0xFF800000 -> NaN_res=1, legal=0.
//     0xFF800000 + 0x3F800000 -> inf_res=1, res_sig=1.
//  4. 0x3F800000 + 0x27800001 (del=48, clamped): mant_op_2=0 without FP_PREP_STICKY_EN,
//     mant_op_2=1 with it.
//  5. Stream 5 pairs back-to-back with out_ready=0 for 4 cycles: in_ready drops after
//     2 accepts, outputs hold stable; on release all 5 emerge in order, 1/cycle.
//  6. Drop rst_n with both stages full -> out_valid=0 and outputs=0 the same cycle;
//     after release, in_ready=1 and the next pair emerges 2 cycles after accept.

Source files
------------

// File: rtl/fp_add_preparer_pipe.sv
// fp_add_preparer_pipe
// First stage of the FP adder. Two-stage pipeline with valid/ready on both sides:
//   S1 decodes both operands (NaN/inf/denorm), picks the larger exponent, and
//      registers the exponent difference, the compare flags and the result sign.
//   S2 places both significands, right-aligns the smaller one, converts negative
//      operands to two's complement and registers the final outputs.
// Optional feature: define FP_PREP_STICKY_EN to OR the bits lost during alignment
// into bit 0 of the shifted mantissa (clamped shifts give 1 for a nonzero significand).
module fp_add_preparer_pipe #(
    parameter int  EXP_W  = 8,
    parameter int  FRAC_W = 23,
    localparam int OP_W   = 1 + EXP_W + FRAC_W,
    localparam int MANT_W = 2 * FRAC_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op_1,
    input  logic [OP_W-1:0]   op_2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              NaN_res,
    output logic              inf_res,
    output logic              res_sig,
    output logic              legal,
    output logic [EXP_W-1:0]  exp_max,
    output logic [MANT_W-1:0] mant_op_1,
    output logic [MANT_W-1:0] mant_op_2
);

    localparam int SIG_W = FRAC_W + 1;

    // Operand decode, index 0 = op_1, index 1 = op_2
    logic [1:0][OP_W-1:0]   op;
    logic [1:0]             dec_sign, dec_nan, dec_inf, dec_den;
    logic [1:0][EXP_W-1:0]  dec_exp, dec_ee;
    logic [1:0][FRAC_W-1:0] dec_frac;
    logic                   c_gr_1, c_gr_2, c_nan, c_inf, c_mag_1_gt, c_mag_2_gt;

    // Stage 1 state
    logic                   s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0]       s1_exp_max_q, s1_exp_max_d;
    logic [EXP_W-1:0]       s1_del_q, s1_del_d;
    logic                   s1_gr_1_q, s1_gr_1_d, s1_gr_2_q, s1_gr_2_d, s1_eq_q, s1_eq_d;
    logic                   s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
    logic                   s1_res_sig_q, s1_res_sig_d;
    logic [1:0]             s1_sign_q, s1_sign_d;
    logic [1:0][SIG_W-1:0]  s1_sig_q, s1_sig_d;

    // Stage 2 (output) state
    logic                   out_valid_q, out_valid_d;
    logic                   nan_res_q, nan_res_d, inf_res_q, inf_res_d;
    logic                   res_sig_q, res_sig_d, legal_q, legal_d;
    logic [EXP_W-1:0]       exp_max_q, exp_max_d;
    logic [MANT_W-1:0]      mant_op_1_q, mant_op_1_d, mant_op_2_q, mant_op_2_d;

    logic                   s1_en, s2_en;
    logic [1:0][MANT_W-1:0] mant_al;

    assign op = {op_2, op_1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_decode
            assign dec_sign[gi] = op[gi][OP_W-1];
            assign dec_exp[gi]  = op[gi][OP_W-2 -: EXP_W];
            assign dec_frac[gi] = op[gi][FRAC_W-1:0];
            assign dec_nan[gi]  = (&dec_exp[gi]) & (|dec_frac[gi]);
            assign dec_inf[gi]  = (&dec_exp[gi]) & ~(|dec_frac[gi]);
            assign dec_den[gi]  = ~(|dec_exp[gi]);
            // Denormals behave as exponent 1 with no hidden bit
            assign dec_ee[gi]   = dec_den[gi] ? EXP_W'(1) : dec_exp[gi];
        end
    endgenerate

    assign c_gr_1     = dec_ee[0] > dec_ee[1];
    assign c_gr_2     = dec_ee[1] > dec_ee[0];
    assign c_nan      = (|dec_nan) | ((&dec_inf) & (dec_sign[0] ^ dec_sign[1]));
    assign c_inf      = ~c_nan & (|dec_inf);
    assign c_mag_1_gt = {dec_ee[0], dec_frac[0]} > {dec_ee[1], dec_frac[1]};
    assign c_mag_2_gt = {dec_ee[1], dec_frac[1]} > {dec_ee[0], dec_frac[0]};

    // Backpressure: a stage advances when the stage after it can take its contents
    assign s2_en    = ~out_valid_q | out_ready;
    assign s1_en    = ~s1_valid_q | s2_en;
    assign in_ready = s1_en;

    // Stage 1 next state: decode, exponent compare and result sign
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_exp_max_d = s1_exp_max_q;
        s1_del_d     = s1_del_q;
        s1_gr_1_d    = s1_gr_1_q;
        s1_gr_2_d    = s1_gr_2_q;
        s1_eq_d      = s1_eq_q;
        s1_nan_d     = s1_nan_q;
        s1_inf_d     = s1_inf_q;
        s1_res_sig_d = s1_res_sig_q;
        s1_sign_d    = s1_sign_q;
        s1_sig_d     = s1_sig_q;
        if (s1_en) begin
            s1_valid_d   = in_valid;
            s1_exp_max_d = (dec_exp[0] > dec_exp[1]) ? dec_exp[0] : dec_exp[1];
            s1_del_d     = c_gr_1 ? (dec_ee[0] - dec_ee[1]) : (dec_ee[1] - dec_ee[0]);
            s1_gr_1_d    = c_gr_1;
            s1_gr_2_d    = c_gr_2;
            s1_eq_d      = ~c_gr_1 & ~c_gr_2;
            s1_nan_d     = c_nan;
            s1_inf_d     = c_inf;
            s1_sign_d    = dec_sign;
            s1_sig_d[0]  = {~dec_den[0], dec_frac[0]};
            s1_sig_d[1]  = {~dec_den[1], dec_frac[1]};
            if (c_nan) begin
                s1_res_sig_d = 1'b0;
            end else if (c_inf) begin
                s1_res_sig_d = dec_inf[0] ? dec_sign[0] : dec_sign[1];
            end else if (c_mag_1_gt) begin
                s1_res_sig_d = dec_sign[0];
            end else if (c_mag_2_gt) begin
                s1_res_sig_d = dec_sign[1];
            end else begin
                // Exact tie: opposite signs cancel to +0, equal signs keep the sign
                s1_res_sig_d = dec_sign[0] & dec_sign[1];
            end
        end
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_align
            logic [MANT_W-1:0] placed, shifted, aligned;
            logic [EXP_W-1:0]  shamt;
            logic              shift_en, clamp;

            // Significand sits below the sign and carry headroom bits
            assign placed   = {2'b00, s1_sig_q[gi], {SIG_W{1'b0}}};
            // Only the operand with the smaller effective exponent shifts
            assign shift_en = ~s1_eq_q & ((gi == 0) ? s1_gr_2_q : s1_gr_1_q);
            assign shamt    = shift_en ? s1_del_q : '0;
            assign clamp    = 32'(shamt) >= 32'(MANT_W - 2);
            assign shifted  = clamp ? '0 : (placed >> shamt);
`ifdef FP_PREP_STICKY_EN
            logic lost;
            assign lost     = clamp ? (|placed)
                                    : (|(placed & ~({MANT_W{1'b1}} << shamt)));
            assign aligned  = {shifted[MANT_W-1:1], shifted[0] | lost};
`else
            assign aligned  = shifted;
`endif
            assign mant_al[gi] = (s1_nan_q | s1_inf_q) ? '0 :
                                 s1_sign_q[gi] ? (~aligned + MANT_W'(1)) : aligned;
        end
    endgenerate

    // Stage 2 next state: capture aligned mantissas and special-case flags
    always_comb begin
        out_valid_d = out_valid_q;
        nan_res_d   = nan_res_q;
        inf_res_d   = inf_res_q;
        res_sig_d   = res_sig_q;
        legal_d     = legal_q;
        exp_max_d   = exp_max_q;
        mant_op_1_d = mant_op_1_q;
        mant_op_2_d = mant_op_2_q;
        if (s2_en) begin
            out_valid_d = s1_valid_q;
            nan_res_d   = s1_nan_q;
            inf_res_d   = s1_inf_q;
            res_sig_d   = s1_res_sig_q;
            legal_d     = ~s1_nan_q & ~s1_inf_q;
            exp_max_d   = s1_exp_max_q;
            mant_op_1_d = mant_al[0];
            mant_op_2_d = mant_al[1];
        end
    end

    // Pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_exp_max_q <= '0;
            s1_del_q     <= '0;
            s1_gr_1_q    <= 1'b0;
            s1_gr_2_q    <= 1'b0;
            s1_eq_q      <= 1'b0;
            s1_nan_q     <= 1'b0;
            s1_inf_q     <= 1'b0;
            s1_res_sig_q <= 1'b0;
            s1_sign_q    <= '0;
            s1_sig_q     <= '0;
            out_valid_q  <= 1'b0;
            nan_res_q    <= 1'b0;
            inf_res_q    <= 1'b0;
            res_sig_q    <= 1'b0;
            legal_q      <= 1'b0;
            exp_max_q    <= '0;
            mant_op_1_q  <= '0;
            mant_op_2_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_exp_max_q <= s1_exp_max_d;
            s1_del_q     <= s1_del_d;
            s1_gr_1_q    <= s1_gr_1_d;
            s1_gr_2_q    <= s1_gr_2_d;
            s1_eq_q      <= s1_eq_d;
            s1_nan_q     <= s1_nan_d;
            s1_inf_q     <= s1_inf_d;
            s1_res_sig_q <= s1_res_sig_d;
            s1_sign_q    <= s1_sign_d;
            s1_sig_q     <= s1_sig_d;
            out_valid_q  <= out_valid_d;
            nan_res_q    <= nan_res_d;
            inf_res_q    <= inf_res_d;
            res_sig_q    <= res_sig_d;
            legal_q      <= legal_d;
            exp_max_q    <= exp_max_d;
            mant_op_1_q  <= mant_op_1_d;
            mant_op_2_q  <= mant_op_2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign NaN_res   = nan_res_q;
    assign inf_res   = inf_res_q;
    assign res_sig   = res_sig_q;
    assign legal     = legal_q;
    assign exp_max   = exp_max_q;
    assign mant_op_1 = mant_op_1_q;
    assign mant_op_2 = mant_op_2_q;

endmodule

// File: tb/tb_fp_add_preparer_pipe.sv
// Testbench for fp_add_preparer_pipe (FP32 configuration).
// Known vectors from a table, handshake corner sequences, and random traffic
// checked against an arithmetic reference model through an expected-result queue.
module tb_fp_add_preparer_pipe;

    localparam int MW    = 50;
    localparam int OUT_W = 4 + 8 + 2 * MW;

    typedef struct {
        logic          nan;
        logic          inf;
        logic          sig;
        logic          lgl;
        logic [7:0]    emax;
        logic [MW-1:0] m1;
        logic [MW-1:0] m2;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        res_t        r;
    } vec_t;

    logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   op_1, op_2;
    logic          NaN_res, inf_res, res_sig, legal;
    logic [7:0]    exp_max;
    logic [MW-1:0] mant_op_1, mant_op_2;
    logic [OUT_W-1:0] outs;

    assign outs = {NaN_res, inf_res, res_sig, legal, exp_max, mant_op_1, mant_op_2};

    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;
    res_t exp_q[$];
    res_t dummy;
    logic acc_f, emit_f, stall_prev;
    logic [OUT_W-1:0] snap;

    fp_add_preparer_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_1      (op_1),
        .op_2      (op_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .NaN_res   (NaN_res),
        .inf_res   (inf_res),
        .res_sig   (res_sig),
        .legal     (legal),
        .exp_max   (exp_max),
        .mant_op_1 (mant_op_1),
        .mant_op_2 (mant_op_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the decoded fields
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
        res_t r;
        logic [31:0] opv [2];
        int s [2], e [2], ee [2];
        bit isnan [2], isinf [2];
        longint unsigned f [2], sg [2], mag [2], m [2];
        longint unsigned full, v, kept, pw;
        int d;
        bit lost;
        opv[0] = a;
        opv[1] = b;
        full = 64'd1 << MW;
        for (int i = 0; i < 2; i++) begin
            s[i]     = int'(opv[i][31]);
            e[i]     = int'(opv[i][30:23]);
            f[i]     = longint'(opv[i][22:0]);
            isnan[i] = (e[i] == 255) && (f[i] != 0);
            isinf[i] = (e[i] == 255) && (f[i] == 0);
            ee[i]    = (e[i] == 0) ? 1 : e[i];
            sg[i]    = ((e[i] == 0) ? 0 : (64'd1 << 23)) + f[i];
            mag[i]   = longint'(ee[i]) * (64'd1 << 23) + f[i];
        end
        r.emax = 8'((e[0] > e[1]) ? e[0] : e[1]);
        r.nan  = isnan[0] || isnan[1] || (isinf[0] && isinf[1] && (s[0] != s[1]));
        r.inf  = !r.nan && (isinf[0] || isinf[1]);
        r.lgl  = !r.nan && !r.inf;
        if (r.nan)                r.sig = 1'b0;
        else if (r.inf)           r.sig = 1'(isinf[0] ? s[0] : s[1]);
        else if (mag[0] > mag[1]) r.sig = 1'(s[0]);
        else if (mag[1] > mag[0]) r.sig = 1'(s[1]);
        else                      r.sig = 1'((s[0] == s[1]) ? s[0] : 0);
        for (int i = 0; i < 2; i++) begin
            d = (ee[1-i] > ee[i]) ? (ee[1-i] - ee[i]) : 0;
            v = sg[i] * (64'd1 << 24);
            if (d >= 48) begin
                kept = 0;
                lost = (v != 0);
            end else begin
                pw   = 64'd1 << d;
                kept = v / pw;
                lost = (v % pw) != 0;
            end
`ifdef FP_PREP_STICKY_EN
            if (lost) kept = kept | 64'd1;
`else
            if (lost) kept = kept + 0;
`endif
            if (s[i] != 0) kept = (full - kept) % full;
            if (!r.lgl) kept = 0;
            m[i] = kept;
        end
        r.m1 = MW'(m[0]);
        r.m2 = MW'(m[1]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic nan, input logic inf, input logic sig,
                                input logic lgl, input logic [7:0] emax,
                                input logic [MW-1:0] m1, input logic [MW-1:0] m2);
        vec_t v;
        v.a      = a;
        v.b      = b;
        v.r.nan  = nan;
        v.r.inf  = inf;
        v.r.sig  = sig;
        v.r.lgl  = lgl;
        v.r.emax = emax;
        v.r.m1   = m1;
        v.r.m2   = m2;
        return v;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        logic        s;
        int          k;
        s = 1'($urandom_range(0, 1));
        f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        k = int'($urandom_range(0, 9));
        if (k == 0)      e = 8'd0;
        else if (k == 1) e = 8'd255;
        else if (k < 7)  e = 8'(97 + $urandom_range(0, 60));
        else             e = 8'($urandom);
        return {s, e, f};
    endfunction

    function automatic logic [31:0] rand_pair(input logic [31:0] a);
        int k;
        k = int'($urandom_range(0, 5));
        if (k == 0)      return a ^ 32'h8000_0000;
        else if (k < 3)  return {1'($urandom), 8'(a[30:23] + $urandom_range(0, 4) - 2), 23'($urandom)};
        else             return rand_op();
    endfunction

    task automatic check_out();
        res_t e;
        checks++;
        txn++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL out_unexpected: got out_valid=1 required no pending result");
            return;
        end
        e = exp_q.pop_front();
        if (outs !== {e.nan, e.inf, e.sig, e.lgl, e.emax, e.m1, e.m2}) begin
            failures++;
            $display("FAIL result_%0d: got nan=%b inf=%b sig=%b legal=%b emax=%h m1=%h m2=%h required nan=%b inf=%b sig=%b legal=%b emax=%h m1=%h m2=%h",
                     txn, NaN_res, inf_res, res_sig, legal, exp_max, mant_op_1, mant_op_2,
                     e.nan, e.inf, e.sig, e.lgl, e.emax, e.m1, e.m2);
        end else begin
            $display("txn %0d ok: nan=%b inf=%b sig=%b legal=%b emax=%h m1=%h m2=%h",
                     txn, NaN_res, inf_res, res_sig, legal, exp_max, mant_op_1, mant_op_2);
        end
    endtask

    // One cycle: drive at the falling edge, observe 1 time unit later, wait next falling edge
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input res_t er);
        in_valid  = iv;
        op_1      = a;
        op_2      = b;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            checks++;
            if (!out_valid || outs !== snap) begin
                failures++;
                $display("FAIL hold_stable: got valid=%b outs=%h required valid=1 outs=%h",
                         out_valid, outs, snap);
            end
        end
        emit_f = out_valid & out_ready;
        acc_f  = in_valid & in_ready;
        if (emit_f) check_out();
        if (acc_f) exp_q.push_back(er);
        stall_prev = out_valid & ~out_ready;
        snap       = outs;
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, dummy);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || outs !== '0) begin
            failures++;
            $display("FAIL %s: got out_valid=%b in_ready=%b outs=%h required out_valid=0 in_ready=1 outs=0",
                     name, out_valid, in_ready, outs);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tab [10];
        logic [31:0] pa [6], pb [6], a, b;
        int idx, pend, emits, lat, sent;
        logic [MW-1:0] m4;

`ifdef FP_PREP_STICKY_EN
        m4 = 50'h1;
`else
        m4 = 50'h0;
`endif
        tab[0] = mk(32'h3F800000, 32'h3F800000, 0, 0, 0, 1, 8'h7F, 50'h0_8000_0000_0000, 50'h0_8000_0000_0000);
        tab[1] = mk(32'h3F800000, 32'hBF000000, 0, 0, 0, 1, 8'h7F, 50'h0_8000_0000_0000, 50'h3_C000_0000_0000);
        tab[2] = mk(32'h7F800000, 32'hFF800000, 1, 0, 0, 0, 8'hFF, 50'h0, 50'h0);
        tab[3] = mk(32'hFF800000, 32'h3F800000, 0, 1, 1, 0, 8'hFF, 50'h0, 50'h0);
        tab[4] = mk(32'h3F800000, 32'h27800001, 0, 0, 0, 1, 8'h7F, 50'h0_8000_0000_0000, m4);
        tab[5] = mk(32'hBF800000, 32'h3F800000, 0, 0, 0, 1, 8'h7F, 50'h3_8000_0000_0000, 50'h0_8000_0000_0000);
        tab[6] = mk(32'hC0000000, 32'h3F800000, 0, 0, 1, 1, 8'h80, 50'h3_8000_0000_0000, 50'h0_4000_0000_0000);
        tab[7] = mk(32'h7FC00000, 32'h3F800000, 1, 0, 0, 0, 8'hFF, 50'h0, 50'h0);
        tab[8] = mk(32'h00000001, 32'h00000001, 0, 0, 0, 1, 8'h00, 50'h0_0000_0100_0000, 50'h0_0000_0100_0000);
        tab[9] = mk(32'h80000000, 32'h80000000, 0, 0, 1, 1, 8'h00, 50'h0, 50'h0);

        dummy      = tab[0].r;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        op_1       = 32'h0;
        op_2       = 32'h0;
        stall_prev = 1'b0;
        snap       = '0;
        rst_n      = 1'b1;
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, presented back to back
        idx = 0;
        for (int c = 0; c < 60 && idx < 10; c++) begin
            step(1'b1, tab[idx].a, tab[idx].b, 1'b1, tab[idx].r);
            if (acc_f) idx++;
        end
        checks++;
        if (idx != 10) begin
            failures++;
            $display("FAIL table_accept: got %0d accepted required 10", idx);
        end
        drain(20);

        // Five pairs against a stalled output for four cycles
        for (int i = 0; i < 5; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_pair(pa[i]);
        end
        pa[5] = 32'h0;
        pb[5] = 32'h0;
        pend  = 0;
        emits = 0;
        for (int c = 0; c < 12; c++) begin
            step(pend < 5, pa[pend], pb[pend], c >= 4, model(pa[pend], pb[pend]));
            if (acc_f) pend++;
            if (c >= 4 && c <= 8 && emit_f) emits++;
            if (c == 3) begin
                checks++;
                if (pend != 2) begin
                    failures++;
                    $display("FAIL stall_accepts: got %0d required 2", pend);
                end
            end
        end
        checks++;
        if (emits != 5 || pend != 5) begin
            failures++;
            $display("FAIL stall_release: got emits=%0d accepted=%0d required 5 and 5", emits, pend);
        end
        drain(10);

        // Reset with both stages full
        a = rand_op();
        b = rand_pair(a);
        step(1'b1, a, b, 1'b0, model(a, b));
        step(1'b1, b, a, 1'b0, model(b, a));
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL fill_before_reset: got out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_midflight");
        exp_q.delete();
        stall_prev = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a = rand_op();
        b = rand_pair(a);
        step(1'b1, a, b, 1'b1, model(a, b));
        checks++;
        if (!acc_f) begin
            failures++;
            $display("FAIL post_reset_accept: got accept=0 required 1");
        end
        lat = 1;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, dummy);
            if (emit_f) break;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL post_reset_latency: got %0d required 2", lat);
        end
        drain(10);

        // Random traffic with random backpressure
        sent = 0;
        a    = rand_op();
        b    = rand_pair(a);
        for (int c = 0; c < 800 && sent < 250; c++) begin
            step($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0, model(a, b));
            if (acc_f) begin
                sent++;
                a = rand_op();
                b = rand_pair(a);
            end
        end
        drain(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
